// File: rtl/pim_pkg.sv
// rtl/pim_pkg.sv - shared defaults and FSM state type for the PIM weight loader
package pim_pkg;

    localparam int DEF_INPUT_BIT = 6;
    localparam int DEF_ROW_ELEMS = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_WRITE = 2'd2
    } wload_state_t;

    // Lane index width; a single-lane row still needs a 1-bit index register.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pim_row_packer.sv
// rtl/pim_row_packer.sv - lane register file, lane index and zero padding for one crossbar row (optional PIM_WLOAD_PARITY_EN)
module pim_row_packer
    import pim_pkg::*;
#(
    parameter int INPUT_BIT = DEF_INPUT_BIT,
    parameter int ROW_ELEMS = DEF_ROW_ELEMS
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           store,
    input  logic                           last,
    input  logic                           clear,
    input  logic [INPUT_BIT-1:0]           data,
    output logic                           full,
    output logic [ROW_ELEMS*INPUT_BIT-1:0] row,
    output logic                           par
);

    localparam int IDX_W = idx_width(ROW_ELEMS);

    logic [IDX_W-1:0]               idx;
    logic [ROW_ELEMS*INPUT_BIT-1:0] row_next;

    assign full = (idx == IDX_W'(ROW_ELEMS - 1));

    // Lane 0 is the MSB lane; a final beat in a partial row clears every lane above it.
    always_comb begin
        row_next = row;
        if (store) begin
            for (int k = 0; k < ROW_ELEMS; k++) begin
                if (IDX_W'(k) == idx) begin
                    row_next[(ROW_ELEMS-k)*INPUT_BIT-1 -: INPUT_BIT] = data;
                end else if (last && (IDX_W'(k) > idx)) begin
                    row_next[(ROW_ELEMS-k)*INPUT_BIT-1 -: INPUT_BIT] = '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            row <= '0;
            idx <= '0;
        end else begin
            row <= row_next;
            if (clear) begin
                idx <= '0;
            end else if (store) begin
                idx <= idx + IDX_W'(1);
            end
        end
    end

`ifdef PIM_WLOAD_PARITY_EN
    // Parity follows the row register exactly, so it is computed from the next-row value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            par <= 1'b0;
        end else begin
            par <= ^row_next;
        end
    end
`else
    assign par = 1'b0;
`endif

endmodule

// File: rtl/pim_weight_loader.sv
// rtl/pim_weight_loader.sv - streams signed weights into crossbar rows (optional PIM_WLOAD_PARITY_EN)
module pim_weight_loader
    import pim_pkg::*;
#(
    parameter int INPUT_BIT = DEF_INPUT_BIT,
    parameter int ROW_ELEMS = DEF_ROW_ELEMS,
    parameter int ADDR_W    = 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [ADDR_W-1:0]              cfg_base_addr,
    input  logic                           s_valid,
    output logic                           s_ready,
    input  logic [INPUT_BIT-1:0]           s_data,
    input  logic                           s_last,
    output logic                           wr_en,
    output logic [ADDR_W-1:0]              wr_addr,
    output logic [ROW_ELEMS*INPUT_BIT-1:0] wr_data,
    input  logic                           wr_ack,
    output logic                           wr_par,
    output logic                           done
);

    wload_state_t state;
    wload_state_t state_next;
    logic         accept;
    logic         ack_take;
    logic         row_full;
    logic         last_q;

    assign accept = s_valid && s_ready;

    always_comb begin
        state_next = state;
        wr_en      = 1'b0;
        ack_take   = 1'b0;
        case (state)
            ST_IDLE, ST_FILL: begin
                if (accept) begin
                    state_next = (s_last || row_full) ? ST_WRITE : ST_FILL;
                end
            end
            ST_WRITE: begin
                wr_en = 1'b1;
                if (wr_ack) begin
                    ack_take   = 1'b1;
                    state_next = last_q ? ST_IDLE : ST_FILL;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // s_ready is registered so it stays low through reset and rises one edge after release.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            s_ready <= 1'b0;
            done    <= 1'b0;
            last_q  <= 1'b0;
            wr_addr <= '0;
        end else begin
            state   <= state_next;
            s_ready <= (state_next != ST_WRITE);
            done    <= ack_take && last_q;
            if (accept && s_last) begin
                last_q <= 1'b1;
            end else if (ack_take) begin
                last_q <= 1'b0;
            end
            if (accept && (state == ST_IDLE)) begin
                wr_addr <= cfg_base_addr;
            end else if (ack_take) begin
                wr_addr <= wr_addr + ADDR_W'(1);
            end
        end
    end

    pim_row_packer #(
        .INPUT_BIT (INPUT_BIT),
        .ROW_ELEMS (ROW_ELEMS)
    ) u_packer (
        .clk   (clk),
        .rst_n (rst_n),
        .store (accept),
        .last  (s_last),
        .clear (ack_take),
        .data  (s_data),
        .full  (row_full),
        .row   (wr_data),
        .par   (wr_par)
    );

endmodule

// File: tb/tb_pim_weight_loader.sv
// tb/tb_pim_weight_loader.sv - randomized self-checking bench for pim_weight_loader
module tb_pim_weight_loader;

    localparam int W = 6;
    localparam int R = 32;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [0:0]     cfg_base_addr = 1'b0;
    logic           s_valid = 1'b0;
    logic           s_ready;
    logic [W-1:0]   s_data = '0;
    logic           s_last = 1'b0;
    logic           wr_en;
    logic [0:0]     wr_addr;
    logic [R*W-1:0] wr_data;
    logic           wr_ack = 1'b0;
    logic           wr_par;
    logic           done;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pim_weight_loader dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cfg_base_addr (cfg_base_addr),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .s_data        (s_data),
        .s_last        (s_last),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .wr_ack        (wr_ack),
        .wr_par        (wr_par),
        .done          (done)
    );

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Row r of the matrix: element j sits at bit offset (R-1-k)*W, missing elements are zero.
    function automatic logic [R*W-1:0] exp_row(input logic [W-1:0] el[$], input int r);
        logic [R*W-1:0] acc = '0;
        for (int k = 0; k < R; k++) begin
            int j = r * R + k;
            if (j < el.size()) acc = acc | ((R*W)'(el[j]) << ((R - 1 - k) * W));
        end
        return acc;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; s_valid = 1'b0; s_last = 1'b0; wr_ack = 1'b0;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            check("rst:wr_en",   256'(wr_en),   256'(0));
            check("rst:done",    256'(done),    256'(0));
            check("rst:s_ready", 256'(s_ready), 256'(0));
            check("rst:wr_addr", 256'(wr_addr), 256'(0));
            check("rst:wr_data", 256'(wr_data), 256'(0));
            check("rst:wr_par",  256'(wr_par),  256'(0));
        end
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("post_rst:s_ready", 256'(s_ready), 256'(1));
        check("post_rst:wr_en",   256'(wr_en),   256'(0));
    endtask

    task automatic run_matrix(input string name, input logic [W-1:0] el[$], input logic base,
                              input int stall, input int gap_pct, input bit ack_noise,
                              input int abort_after);
        int             accepted = 0;
        int             row = 0;
        int             wait_cnt = 0;
        bit             model_write = 0;
        bit             done_exp = 0;
        bit             finished = 0;
        bit             take_beat;
        bit             take_ack;
        logic [R*W-1:0] exp_d;
        logic           exp_par;
        logic           exp_addr;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            check({name, ":wr_en"},   256'(wr_en),   256'(model_write));
            check({name, ":s_ready"}, 256'(s_ready), 256'(!model_write));
            check({name, ":done"},    256'(done),    256'(done_exp));
            if (model_write) begin
                exp_d = exp_row(el, row);
                exp_addr = 1'((int'(base) + row) % 2);
`ifdef PIM_WLOAD_PARITY_EN
                exp_par = ^exp_d;
`else
                exp_par = 1'b0;
`endif
                check({name, ":wr_addr"}, 256'(wr_addr), 256'(exp_addr));
                check({name, ":wr_data"}, 256'(wr_data), 256'(exp_d));
                check({name, ":wr_par"},  256'(wr_par),  256'(exp_par));
            end
            if (done_exp || (abort_after > 0 && accepted >= abort_after)) begin
                finished = 1;
                s_valid = 1'b0; s_last = 1'b0; wr_ack = 1'b0;
                break;
            end
            cfg_base_addr = (accepted == 0) ? base : ~base;
            if (accepted < el.size() && ($urandom_range(99) >= gap_pct)) begin
                s_valid = 1'b1;
                s_data  = el[accepted];
                s_last  = (accepted == int'(el.size()) - 1);
            end else begin
                s_valid = 1'b0;
                s_data  = W'($urandom);
                s_last  = 1'($urandom_range(1));
            end
            if (model_write) begin
                wait_cnt++;
                wr_ack = (wait_cnt > stall);
            end else begin
                wr_ack = ack_noise ? 1'($urandom_range(1)) : 1'b0;
            end
            take_beat = s_valid && !model_write;
            take_ack  = wr_ack && model_write;
            @(posedge clk);
            if (take_beat) begin
                accepted++;
                if ((accepted % R == 0) || (accepted == int'(el.size()))) begin
                    model_write = 1;
                    wait_cnt = 0;
                end
            end
            if (take_ack) begin
                model_write = 0;
                row++;
                if (row * R >= int'(el.size())) done_exp = 1;
            end
        end
        if (!finished) check({name, ":timeout"}, 256'(0), 256'(1));
    endtask

    initial begin
        logic [W-1:0] el[$];

        do_reset();

        el = {};
        for (int i = 1; i <= 32; i++) el.push_back(W'(i));
        run_matrix("full_row", el, 1'b0, 0, 0, 0, 0);

        el = {6'h05, 6'h3F, 6'h07};
        run_matrix("partial_row", el, 1'b0, 2, 0, 0, 0);

        el = {};
        for (int i = 0; i < 64; i++) el.push_back(W'($urandom));
        run_matrix("ack_stall", el, 1'b0, 10, 0, 0, 0);

        el = {};
        for (int i = 0; i < 64; i++) el.push_back(W'($urandom));
        run_matrix("wrap", el, 1'b1, 1, 0, 1, 0);

        el = {};
        for (int i = 0; i < 32; i++) el.push_back(W'($urandom));
        run_matrix("pre_reset", el, 1'b0, 0, 0, 0, 10);
        do_reset();
        run_matrix("after_reset", el, 1'b1, 0, 0, 0, 0);

        el = {6'h07};
        run_matrix("parity_single", el, 1'b0, 0, 0, 0, 0);

        for (int t = 0; t < 6; t++) begin
            el = {};
            for (int i = 0; i < int'($urandom_range(80, 1)); i++) el.push_back(W'($urandom));
            run_matrix("random", el, 1'($urandom_range(1)), int'($urandom_range(3)), 30, 1, 0);
        end

        @(negedge clk);
        check("final:done", 256'(done), 256'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
